// File: rtl/cbfp_denorm.sv
// cbfp_denorm: restores 16-lane block-floating-point mantissas to a shared
// fixed-point scale. This is the inverse of CBFP normalization.
//   clk, rstn            : clock, async active-low reset
//   real_in/imag_in      : per-lane signed mantissas (BW_IN)
//   index_in             : per-lane block exponent (BW_IDX, unsigned)
//   in_valid             : batch qualifier (no backpressure)
//   err_clr              : clears sticky idx_err (a concurrent mismatch wins)
//   real_out/imag_out    : restored data (BW_OUT), 2-cycle latency, held when idle
//   valid_out/last_out   : batch valid / final batch of a block
//   sat_out              : some lane/component clipped in this batch
//   idx_err              : sticky, index not uniform within a block

// One component of one lane. d = SHIFT_BIAS - index, as a signed value.
// A positive d shifts left and saturates. A negative d gives a floor-rounded
// arithmetic right shift.
module cbfp_denorm_shift #(
    parameter int BW_IN      = 11,
    parameter int BW_OUT     = 16,
    parameter int BW_IDX     = 5,
    parameter int SHIFT_BIAS = 12
) (
    input  logic signed [BW_IN-1:0]  din,
    input  logic signed [BW_IDX:0]   d,
    output logic signed [BW_OUT-1:0] dout,
    output logic                     sat
);
    // Wide enough to hold the largest left shift at full precision.
    localparam int WF = (BW_IN + SHIFT_BIAS > BW_OUT) ? BW_IN + SHIFT_BIAS : BW_OUT + 1;

    logic signed [WF-1:0]     wide, lsh;
    logic signed [BW_IN-1:0]  rsh;
    logic [BW_IDX:0]          amt;
    logic [WF-BW_OUT:0]       hi;

    always_comb begin
        wide = WF'(din);
        amt  = d[BW_IDX] ? $unsigned(-d) : $unsigned(d);
        lsh  = wide <<< amt;
        // A shift of BW_IN or more fills with the sign: the result is 0 or -1.
        rsh  = din >>> amt;
        hi   = lsh[WF-1:BW_OUT-1];
        sat  = 1'b0;
        dout = BW_OUT'(rsh);
        if (!d[BW_IDX]) begin
            if ((&hi) || (~|hi)) begin
                dout = lsh[BW_OUT-1:0];
            end else begin
                sat  = 1'b1;
                dout = lsh[WF-1] ? {1'b1, {(BW_OUT-1){1'b0}}} : {1'b0, {(BW_OUT-1){1'b1}}};
            end
        end
    end
endmodule

module cbfp_denorm #(
    parameter int BW_IN      = 11,
    parameter int BW_OUT     = 16,
    parameter int BW_IDX     = 5,
    parameter int SHIFT_BIAS = 12,
    parameter int BLOCK_SIZE = 64,
    parameter int BATCH_SIZE = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [0:BATCH_SIZE-1][BW_IN-1:0]      real_in,
    input  logic [0:BATCH_SIZE-1][BW_IN-1:0]      imag_in,
    input  logic [0:BATCH_SIZE-1][BW_IDX-1:0]     index_in,
    input  logic                                  in_valid,
    input  logic                                  err_clr,
    output logic [0:BATCH_SIZE-1][BW_OUT-1:0]     real_out,
    output logic [0:BATCH_SIZE-1][BW_OUT-1:0]     imag_out,
    output logic                                  valid_out,
    output logic                                  last_out,
    output logic                                  sat_out,
    output logic                                  idx_err
);
    localparam int NB     = BLOCK_SIZE / BATCH_SIZE;
    localparam int BCW    = $clog2(NB);
    localparam int STAGES = 2;
    localparam logic [BW_IDX:0] BIAS = (BW_IDX+1)'(SHIFT_BIAS);

    typedef enum logic {FIRST, REST} state_t;

    state_t                              state;
    logic [BCW-1:0]                      bcnt;
    logic [BW_IDX-1:0]                   ref_idx, cmp_idx;
    logic                                mism, bc_last;
    logic [STAGES:1]                     vld_pipe;

    logic [0:BATCH_SIZE-1][BW_IN-1:0]    s1_re, s1_im;
    logic [0:BATCH_SIZE-1][BW_IDX:0]     s1_d, d_c;
    logic                                s1_last;

    logic [0:BATCH_SIZE-1][BW_OUT-1:0]   nd_re, nd_im;
    logic [BATCH_SIZE-1:0]               sat_re, sat_im;

    // NB is a power of two, so the counter wraps by itself.
    assign bc_last = (bcnt == BCW'(NB - 1));

    // The first batch of a block has no reference yet, so lane 0 serves as one.
    always_comb begin
        cmp_idx = (state == FIRST) ? index_in[0] : ref_idx;
        mism    = 1'b0;
        for (int i = 0; i < BATCH_SIZE; i++)
            if (in_valid && index_in[i] != cmp_idx) mism = 1'b1;
    end

    for (genvar i = 0; i < BATCH_SIZE; i++) begin : g_lane
        assign d_c[i] = BIAS - {1'b0, index_in[i]};

        cbfp_denorm_shift #(.BW_IN(BW_IN), .BW_OUT(BW_OUT), .BW_IDX(BW_IDX), .SHIFT_BIAS(SHIFT_BIAS))
            u_re (.din(s1_re[i]), .d(s1_d[i]), .dout(nd_re[i]), .sat(sat_re[i]));
        cbfp_denorm_shift #(.BW_IN(BW_IN), .BW_OUT(BW_OUT), .BW_IDX(BW_IDX), .SHIFT_BIAS(SHIFT_BIAS))
            u_im (.din(s1_im[i]), .d(s1_d[i]), .dout(nd_im[i]), .sat(sat_im[i]));
    end

    // Control: the batch counter, the index-check FSM and the sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= FIRST;
            bcnt    <= '0;
            ref_idx <= '0;
            idx_err <= 1'b0;
        end else begin
            if (mism)         idx_err <= 1'b1;
            else if (err_clr) idx_err <= 1'b0;
            if (in_valid) begin
                bcnt <= bcnt + 1'b1;
                case (state)
                    FIRST: begin
                        ref_idx <= index_in[0];
                        state   <= REST;
                    end
                    REST: if (bc_last) state <= FIRST;
                    default: state <= FIRST;
                endcase
            end
        end
    end

    // Datapath pipeline: stage 1 captures the inputs, stage 2 shifts and saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_d     <= '0;
            s1_last  <= 1'b0;
            real_out <= '0;
            imag_out <= '0;
            last_out <= 1'b0;
            sat_out  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid) begin
                s1_re   <= real_in;
                s1_im   <= imag_in;
                s1_d    <= d_c;
                s1_last <= bc_last;
            end
            if (vld_pipe[1]) begin
                real_out <= nd_re;
                imag_out <= nd_im;
            end
            last_out <= vld_pipe[1] & s1_last;
            sat_out  <= vld_pipe[1] & (|sat_re | |sat_im);
        end
    end

    assign valid_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_cbfp_denorm.sv
// Self-checking bench for cbfp_denorm. Batches are checked against an
// arithmetic reference model: scale by 2^(12-idx), floor, clamp to 16 bits,
// with blocks of 4 batches and a sticky non-uniform-index flag.
module tb_cbfp_denorm;
    localparam int N = 16;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [0:N-1][10:0]    real_in, imag_in;
    logic [0:N-1][4:0]     index_in;
    logic                  in_valid = 1'b0, err_clr = 1'b0;
    logic [0:N-1][15:0]    real_out, imag_out;
    logic                  valid_out, last_out, sat_out, idx_err;

    cbfp_denorm dut (
        .clk(clk), .rstn(rstn), .real_in(real_in), .imag_in(imag_in),
        .index_in(index_in), .in_valid(in_valid), .err_clr(err_clr),
        .real_out(real_out), .imag_out(imag_out), .valid_out(valid_out),
        .last_out(last_out), .sat_out(sat_out), .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld, last, sat;
        int re[N];
        int im[N];
    } rec_t;

    rec_t sb[64];
    int   hold_re[N], hold_im[N];
    int   t_re[N], t_im[N], t_idx[N];
    int   total = 0, bad = 0, cyc = 0;
    int   pos = 0, blk_ref = 0;
    bit   exp_err = 0, exp_err_n = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference scaling: value * 2^(12-idx), floor for negative exponents, clamped.
    function automatic int den(input int x, input int idx, output bit s);
        longint v, p;
        int d = 12 - idx;
        s = 0;
        if (d >= 0) v = longint'(x) * (longint'(1) << d);
        else begin
            p = longint'(1) << (-d);
            v = (x >= 0) ? x / p : -((-longint'(x) + p - 1) / p);
        end
        if (v > 32767)  begin v = 32767;  s = 1; end
        if (v < -32768) begin v = -32768; s = 1; end
        return int'(v);
    endfunction

    task automatic check_outputs();
        int k = cyc % 64;
        chk("valid_out", valid_out, sb[k].vld);
        chk("last_out", last_out, sb[k].vld & sb[k].last);
        chk("sat_out", sat_out, sb[k].vld & sb[k].sat);
        chk("idx_err", idx_err, exp_err);
        if (sb[k].vld) begin
            hold_re = sb[k].re;
            hold_im = sb[k].im;
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("real_out[%0d]", i), $signed(real_out[i]), hold_re[i]);
            chk($sformatf("imag_out[%0d]", i), $signed(imag_out[i]), hold_im[i]);
        end
        sb[k].vld = 0; sb[k].last = 0; sb[k].sat = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        exp_err = exp_err_n;
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit clr);
        for (int c = 0; c < n; c++) begin
            in_valid  = 1'b0;
            err_clr   = clr;
            exp_err_n = exp_err & ~clr;
            tick();
        end
        err_clr = 1'b0;
    endtask

    task automatic send(input bit clr);
        int  k = (cyc + 2) % 64;
        bit  mism = 0, s1, s2;
        if (pos == 0) blk_ref = t_idx[0];
        for (int i = 0; i < N; i++) if (t_idx[i] != blk_ref) mism = 1;
        sb[k].vld  = 1;
        sb[k].last = (pos == 3);
        sb[k].sat  = 0;
        for (int i = 0; i < N; i++) begin
            sb[k].re[i] = den(t_re[i], t_idx[i], s1);
            sb[k].im[i] = den(t_im[i], t_idx[i], s2);
            if (s1 || s2) sb[k].sat = 1;
            real_in[i]  = 11'(t_re[i]);
            imag_in[i]  = 11'(t_im[i]);
            index_in[i] = 5'(t_idx[i]);
        end
        pos       = (pos + 1) % 4;
        exp_err_n = mism | (exp_err & ~clr);
        in_valid  = 1'b1;
        err_clr   = clr;
        tick();
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        for (int i = 0; i < 64; i++) begin sb[i].vld = 0; sb[i].last = 0; sb[i].sat = 0; end
        for (int i = 0; i < N; i++) begin hold_re[i] = 0; hold_im[i] = 0; end
        pos = 0; exp_err = 0; exp_err_n = 0;
        #1;
        check_outputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic fill(input int re, input int im, input int idx);
        for (int i = 0; i < N; i++) begin t_re[i] = re; t_im[i] = im; t_idx[i] = idx; end
    endtask

    initial begin
        real_in = '0; imag_in = '0; index_in = '0;
        do_reset();
        idle(1, 0);

        // Unity scale, one full block.
        fill(100, -100, 12);
        repeat (4) send(0);
        idle(3, 0);

        // Left/right shifts, then saturation on the final batch of the block.
        fill(100, -7, 10);    send(0);
        fill(-3, 5, 14);      send(0);
        fill(5, -1, 31);      send(0);
        fill(1023, -1024, 0); send(0);
        idle(3, 1);

        // Gapped block, then a new block at another index (reference relatched).
        for (int b = 0; b < 4; b++) begin
            fill(0, 0, 12);
            for (int i = 0; i < N; i++) begin
                t_re[i] = int'($urandom_range(0, 2047)) - 1024;
                t_im[i] = int'($urandom_range(0, 2047)) - 1024;
            end
            send(0);
            idle(2, 0);
        end
        fill(37, -55, 9);
        repeat (4) send(0);
        idle(2, 0);

        // Lane 7 off by one in batch 2, then clear, then clear racing a new mismatch.
        fill(300, -300, 12); send(0); send(0);
        t_idx[7] = 11; send(0);
        t_idx[7] = 12; send(0);
        idle(2, 0);
        idle(1, 1);
        idle(1, 0);
        fill(10, 20, 12); send(0);
        t_idx[3] = 5; send(1);
        t_idx[3] = 12; send(0); send(0);
        idle(2, 1);

        // Reset in the middle of a block, then a fresh block.
        fill(50, 60, 12); send(0); send(0);
        do_reset();
        fill(-70, 80, 11);
        repeat (4) send(0);
        idle(3, 0);

        // Random blocks with random gaps, exponents and clears.
        for (int b = 0; b < 48; b++) begin
            int bidx = (pos == 0) ? int'($urandom_range(0, 24)) : blk_ref;
            for (int i = 0; i < N; i++) begin
                t_re[i]  = int'($urandom_range(0, 2047)) - 1024;
                t_im[i]  = int'($urandom_range(0, 2047)) - 1024;
                t_idx[i] = bidx;
            end
            if ($urandom_range(0, 7) == 0) t_idx[$urandom_range(0, N-1)] = int'($urandom_range(0, 31));
            send($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), $urandom_range(0, 3) == 0);
        end
        idle(3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
